// File: rtl/acq_sequencer.sv
// Acquisition sequencer: orders reset, start, trigger wait, post-trigger
// delay, stop and readout strobes for the sampling chip's instruction driver.
module acq_sequencer #(
  parameter int RST_CYCLES = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             arm,
  input  logic             abort,
  input  logic             auto_rearm,
  input  logic             trig,
  input  logic [CNT_W-1:0] post_trig_dly,
  input  logic [CNT_W-1:0] timeout,
  input  logic [CNT_W-1:0] readout_len,
  output logic             seq_rst,
  output logic             seq_start,
  output logic             seq_stop,
  output logic             seq_readout,
  output logic             busy,
  output logic             done,
  output logic             timed_out,
  output logic [2:0]       state,
  output logic [7:0]       evt_count
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RESET    = 3'd1,
    S_START    = 3'd2,
    S_ARMED    = 3'd3,
    S_POSTTRIG = 3'd4,
    S_STOP     = 3'd5,
    S_READOUT  = 3'd6,
    S_DONE     = 3'd7
  } st_t;

  // Per-run configuration, frozen when a run enters RESET
  typedef struct packed {
    logic [CNT_W-1:0] dly;
    logic [CNT_W-1:0] tmo;
    logic [CNT_W-1:0] len;
  } cfg_t;

  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);

  st_t              st_q, st_d;
  cfg_t             cfg_q;
  logic [CNT_W-1:0] cnt_q;
  logic             abt_q;
  logic             to_q;
  logic [7:0]       evt_q;

  logic             enter_rst;
  logic             tmo_hit;
  logic [CNT_W-1:0] len_last;

  // Derived compare terms; a zero readout length behaves like one cycle
  assign enter_rst = (st_d == S_RESET) && (st_q != S_RESET);
  assign tmo_hit   = (cfg_q.tmo != '0) && (cnt_q == cfg_q.tmo - ONE);
  assign len_last  = (cfg_q.len == '0) ? '0 : cfg_q.len - ONE;

  // State register
  always_ff @(posedge clk) begin
    if (!rstn) st_q <= S_IDLE;
    else       st_q <= st_d;
  end

  // Next-state logic; abort outranks every other transition
  always_comb begin
    st_d = st_q;
    case (st_q)
      S_IDLE:     if (arm && !abort) st_d = S_RESET;
      S_RESET:    if (abort) st_d = S_IDLE;
                  else if (cnt_q == RST_LAST) st_d = S_START;
      S_START:    st_d = abort ? S_STOP : S_ARMED;
      S_ARMED:    if (abort) st_d = S_STOP;
                  else if (trig) st_d = (cfg_q.dly == '0) ? S_STOP : S_POSTTRIG;
                  else if (tmo_hit) st_d = S_STOP;
      // dly is nonzero here: a zero delay bypasses POSTTRIG
      S_POSTTRIG: if (abort || cnt_q == cfg_q.dly - ONE) st_d = S_STOP;
      S_STOP:     st_d = (abt_q || abort) ? S_IDLE : S_READOUT;
      S_READOUT:  if (abort) st_d = S_IDLE;
                  else if (cnt_q == len_last) st_d = S_DONE;
      S_DONE:     if (abort) st_d = S_IDLE;
                  else st_d = auto_rearm ? S_RESET : S_IDLE;
      default:    st_d = S_IDLE;
    endcase
  end

  // Shared phase counter: restarts on every state change, saturates otherwise
  always_ff @(posedge clk) begin
    if (!rstn)                                 cnt_q <= '0;
    else if (st_d != st_q || st_q == S_IDLE)   cnt_q <= '0;
    else if (cnt_q != '1)                      cnt_q <= cnt_q + ONE;
  end

  // Capture configuration on entry to RESET so mid-run edits wait a run
  always_ff @(posedge clk) begin
    if (!rstn)          cfg_q <= '0;
    else if (enter_rst) cfg_q <= '{dly: post_trig_dly, tmo: timeout, len: readout_len};
  end

  // Abort flag steers STOP back to IDLE instead of READOUT
  always_ff @(posedge clk) begin
    if (!rstn)               abt_q <= 1'b0;
    else if (st_q == S_IDLE) abt_q <= 1'b0;
    else if (abort && (st_q == S_START || st_q == S_ARMED || st_q == S_POSTTRIG))
      abt_q <= 1'b1;
  end

  // Sticky timeout flag; trigger or abort in the same cycle suppresses it
  always_ff @(posedge clk) begin
    if (!rstn)          to_q <= 1'b0;
    else if (enter_rst) to_q <= 1'b0;
    else if (st_q == S_ARMED && !abort && !trig && tmo_hit) to_q <= 1'b1;
  end

  // Completed-run counter, saturating, skips timed-out runs
  always_ff @(posedge clk) begin
    if (!rstn) evt_q <= '0;
    else if (st_q == S_DONE && !to_q && evt_q != 8'hFF) evt_q <= evt_q + 8'd1;
  end

  // Moore output decode from the state register
  always_comb begin
    seq_rst     = (st_q == S_RESET);
    seq_start   = (st_q == S_START);
    seq_stop    = (st_q == S_STOP);
    seq_readout = (st_q == S_READOUT);
    done        = (st_q == S_DONE);
    busy        = (st_q != S_IDLE);
    timed_out   = to_q;
    state       = st_q;
    evt_count   = evt_q;
  end

endmodule

// File: tb/tb_acq_sequencer.sv
// Bench for acq_sequencer: directed vector table, hand-written corner
// sequences and a random run, all checked every cycle against a phase model.
module tb_acq_sequencer;

  localparam int RST_CYCLES = 4;
  localparam int CNT_W      = 16;

  localparam int P_IDLE = 0, P_RESET = 1, P_START = 2, P_ARMED = 3,
                 P_POST = 4, P_STOP = 5, P_RDO = 6, P_DONE = 7;

  logic clk = 1'b0;
  logic rstn, arm, abort, auto_rearm, trig;
  logic [CNT_W-1:0] post_trig_dly, timeout, readout_len;
  logic seq_rst, seq_start, seq_stop, seq_readout, busy, done, timed_out;
  logic [2:0] state;
  logic [7:0] evt_count;

  always #5 clk = ~clk;

  acq_sequencer #(.RST_CYCLES(RST_CYCLES), .CNT_W(CNT_W)) dut (
    .clk(clk), .rstn(rstn), .arm(arm), .abort(abort), .auto_rearm(auto_rearm),
    .trig(trig), .post_trig_dly(post_trig_dly), .timeout(timeout),
    .readout_len(readout_len), .seq_rst(seq_rst), .seq_start(seq_start),
    .seq_stop(seq_stop), .seq_readout(seq_readout), .busy(busy), .done(done),
    .timed_out(timed_out), .state(state), .evt_count(evt_count)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model: phase plus cycles-remaining countdown
  int m_ph = P_IDLE, m_left = 0, m_wait = 0, m_evt = 0;
  int m_d = 0, m_t = 0, m_l = 0;
  bit m_abt = 0, m_to = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, got, exp);
    end
  endtask

  task automatic begin_run();
    m_ph = P_RESET; m_left = RST_CYCLES; m_to = 0;
    m_d = int'(post_trig_dly); m_t = int'(timeout); m_l = int'(readout_len);
  endtask

  // Advance the model by one rising edge using the currently driven inputs
  task automatic model_step();
    if (!rstn) begin
      m_ph = P_IDLE; m_abt = 0; m_to = 0; m_evt = 0; m_d = 0; m_t = 0; m_l = 0;
      return;
    end
    case (m_ph)
      P_IDLE: begin m_abt = 0; if (arm && !abort) begin_run(); end
      P_RESET: if (abort) m_ph = P_IDLE;
               else if (m_left == 1) m_ph = P_START; else m_left--;
      P_START: if (abort) begin m_ph = P_STOP; m_abt = 1; end
               else begin m_ph = P_ARMED; m_wait = 0; end
      P_ARMED: begin
        if (abort) begin m_ph = P_STOP; m_abt = 1; end
        else if (trig) begin
          if (m_d == 0) m_ph = P_STOP; else begin m_ph = P_POST; m_left = m_d; end
        end else begin
          m_wait++;
          if (m_t != 0 && m_wait == m_t) begin m_ph = P_STOP; m_to = 1; end
        end
      end
      P_POST: if (abort) begin m_ph = P_STOP; m_abt = 1; end
              else if (m_left == 1) m_ph = P_STOP; else m_left--;
      P_STOP: if (m_abt || abort) m_ph = P_IDLE;
              else begin m_ph = P_RDO; m_left = (m_l == 0) ? 1 : m_l; end
      P_RDO: if (abort) m_ph = P_IDLE;
             else if (m_left == 1) m_ph = P_DONE; else m_left--;
      default: begin
        if (!m_to && m_evt < 255) m_evt++;
        if (abort) m_ph = P_IDLE;
        else if (auto_rearm) begin_run();
        else m_ph = P_IDLE;
      end
    endcase
  endtask

  function automatic logic [17:0] dut_vec();
    return {seq_rst, seq_start, seq_stop, seq_readout, busy, done, timed_out, state, evt_count};
  endfunction

  function automatic logic [17:0] model_vec();
    logic [2:0] ph;
    logic [7:0] ev;
    ph = 3'(m_ph);
    ev = 8'(m_evt);
    return {m_ph == P_RESET, m_ph == P_START, m_ph == P_STOP, m_ph == P_RDO,
            m_ph != P_IDLE, m_ph == P_DONE, m_to, ph, ev};
  endfunction

  // One clock: update model, let the edge pass, compare away from the edge
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    cyc++;
    chk("model", 32'(dut_vec()), 32'(model_vec()));
  endtask

  typedef struct {
    int d, l, t, trig_at, abort_at;
    int stop_at, rd_first, rd_n, done_at, last_busy, to, inc;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int exp_evt;
    rstn = 0; arm = 0; abort = 0; auto_rearm = 0; trig = 0;
    post_trig_dly = '0; timeout = '0; readout_len = '0;
    tick(); tick();
    chk("reset_vec", 32'(dut_vec()), 32'h0);
    rstn = 1;
    tick();
    chk("idle_vec", 32'(dut_vec()), 32'h0);
    exp_evt = 0;

    //          d  l  t trig abort stop rd1 rdn done last to inc
    tbl[0] = '{3, 5, 0, 10, -1, 14, 15, 5, 20, 20, 0, 1};
    tbl[1] = '{3, 5, 8, -1, -1, 14, 15, 5, 20, 20, 1, 0};
    tbl[2] = '{0, 2, 8, 13, -1, 14, 15, 2, 17, 17, 0, 1};
    tbl[3] = '{0, 0, 0,  7, -1,  8,  9, 1, 10, 10, 0, 1};
    tbl[4] = '{3, 5, 0, -1,  8,  9, -1, 0, -1,  9, 0, 0};
    tbl[5] = '{3, 5, 0, 10, 16, 14, 15, 2, -1, 16, 0, 0};
    tbl[6] = '{2, 1, 1, -1, -1,  7,  8, 1,  9,  9, 1, 0};
    tbl[7] = '{1, 3, 0,  6, -1,  8,  9, 3, 12, 12, 0, 1};

    foreach (tbl[i]) begin
      int c, nrst, nstop, nrd, start_at, stop_at, rd_first, done_at, last_busy;
      c = 0; nrst = 0; nstop = 0; nrd = 0;
      start_at = -1; stop_at = -1; rd_first = -1; done_at = -1; last_busy = -1;
      post_trig_dly = CNT_W'(tbl[i].d); readout_len = CNT_W'(tbl[i].l);
      timeout = CNT_W'(tbl[i].t);
      for (int k = 0; k < 40; k++) begin
        arm = (c == 0); trig = (c == tbl[i].trig_at); abort = (c == tbl[i].abort_at);
        tick();
        c++;
        if (seq_rst) nrst++;
        if (seq_start && start_at < 0) start_at = c;
        if (seq_stop) begin nstop++; if (stop_at < 0) stop_at = c; end
        if (seq_readout) begin nrd++; if (rd_first < 0) rd_first = c; end
        if (done && done_at < 0) done_at = c;
        if (busy) last_busy = c;
      end
      arm = 0; trig = 0; abort = 0;
      exp_evt += tbl[i].inc;
      chk($sformatf("row%0d_rst_len", i), 32'(nrst), RST_CYCLES);
      chk($sformatf("row%0d_start", i), 32'(start_at), RST_CYCLES + 1);
      chk($sformatf("row%0d_nstop", i), 32'(nstop), 1);
      chk($sformatf("row%0d_stop", i), 32'(stop_at), 32'(tbl[i].stop_at));
      chk($sformatf("row%0d_rd_first", i), 32'(rd_first), 32'(tbl[i].rd_first));
      chk($sformatf("row%0d_rd_n", i), 32'(nrd), 32'(tbl[i].rd_n));
      chk($sformatf("row%0d_done", i), 32'(done_at), 32'(tbl[i].done_at));
      chk($sformatf("row%0d_last_busy", i), 32'(last_busy), 32'(tbl[i].last_busy));
      chk($sformatf("row%0d_timed_out", i), 32'(timed_out), 32'(tbl[i].to));
      chk($sformatf("row%0d_evt", i), 32'(evt_count), 32'(exp_evt));
    end

    // rstn mid-POSTTRIG, then re-entry with arm held high
    post_trig_dly = 16'd20; readout_len = 16'd3; timeout = '0;
    arm = 1; tick(); arm = 0;
    repeat (5) tick();
    trig = 1; tick(); trig = 0;
    repeat (3) tick();
    chk("pt_in_posttrig", 32'(state), P_POST);
    rstn = 0; arm = 1; tick();
    chk("pt_rst_vec", 32'(dut_vec()), 32'h0);
    rstn = 1; tick();
    chk("pt_rearm_state", 32'(state), P_RESET);
    chk("pt_rearm_rst", 32'(seq_rst), 1);
    arm = 0; abort = 1; tick(); tick(); abort = 0;

    // rstn mid-READOUT
    post_trig_dly = '0; readout_len = 16'd20;
    arm = 1; tick(); arm = 0;
    repeat (5) tick();
    trig = 1; tick(); trig = 0;
    repeat (4) tick();
    chk("rd_in_readout", 32'(seq_readout), 1);
    rstn = 0; arm = 1; tick();
    chk("rd_rst_vec", 32'(dut_vec()), 32'h0);
    rstn = 1; tick();
    chk("rd_rearm_state", 32'(state), P_RESET);
    arm = 0; abort = 1; tick(); tick(); abort = 0;
    chk("rd_idle", 32'(busy), 0);

    // auto_rearm over 300 runs, delay edited mid-run at run 100
    begin
      int dones, pt, budget;
      bit prev_done, changed;
      int ptlen[300];
      dones = 0; pt = 0; budget = 0; prev_done = 0; changed = 0;
      post_trig_dly = 16'd2; readout_len = 16'd2; timeout = '0;
      auto_rearm = 1; trig = 1;
      arm = 1; tick(); arm = 0;
      while (dones < 300 && budget < 8000) begin
        if (dones == 100 && !changed && m_ph == P_POST) begin
          post_trig_dly = 16'd5; changed = 1;
        end
        tick();
        budget++;
        if (prev_done) chk("rearm_no_gap", 32'(seq_rst), 1);
        prev_done = done;
        if (state == 3'(P_POST)) pt++;
        if (done) begin ptlen[dones] = pt; pt = 0; dones++; end
      end
      chk("rearm_runs", 32'(dones), 300);
      chk("evt_saturate", 32'(evt_count), 255);
      chk("ptdly_before", 32'(ptlen[99]), 2);
      chk("ptdly_changed_run", 32'(ptlen[100]), 2);
      chk("ptdly_next_run", 32'(ptlen[101]), 5);
      auto_rearm = 0; trig = 0;
      abort = 1; tick(); tick(); abort = 0;
      chk("rearm_idle", 32'(busy), 0);
    end

    // Random traffic against the model
    for (int k = 0; k < 4000; k++) begin
      rstn  = ($urandom % 300) != 0;
      arm   = ($urandom % 3) == 0;
      abort = ($urandom % 50) == 0;
      trig  = ($urandom % 8) == 0;
      auto_rearm = $urandom % 2;
      if (($urandom % 10) == 0) begin
        post_trig_dly = CNT_W'($urandom % 5);
        timeout       = CNT_W'($urandom % 12);
        readout_len   = CNT_W'($urandom % 4);
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
